// File: rtl/serial_receiver_if.sv
// Byte-side bundle of the 8N1 UART receiver: received data, strobe and status.
// The oFrameError member exists only when SERIAL_RECEIVER_FRAME_ERROR_EN is defined.
interface serial_receiver_if;
  logic [7:0] oData;
  logic       oReceived;
  logic       oBusy;
`ifdef SERIAL_RECEIVER_FRAME_ERROR_EN
  logic       oFrameError;

  modport master (output oData, output oReceived, output oBusy, output oFrameError);
  modport slave  (input  oData, input  oReceived, input  oBusy, input  oFrameError);
`else
  modport master (output oData, output oReceived, output oBusy);
  modport slave  (input  oData, input  oReceived, input  oBusy);
`endif
endinterface

// File: rtl/serial_receiver.sv
// 8N1 UART receiver: centre-sampled, LSB first, one-cycle strobe per good byte.
// Optional framing-error strobe enabled by SERIAL_RECEIVER_FRAME_ERROR_EN.
//
// state      | meaning
// sIdle      | line idle, waiting for rx low
// sStartBit  | timing to the start-bit centre, rejecting glitches
// sDataBit   | sampling 8 data bits at their centres
// sStopBit   | sampling the stop bit
// sBreak     | stop bit was low; waiting for the line to return high
module serial_receiver #(
  parameter int ClockFrequency = 16000000,
  parameter int BaudRate       = 115200
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iRXD,
  serial_receiver_if.master  rxBus
);

  localparam int TicksPerBit = ClockFrequency / BaudRate;
  localparam int HalfBit     = TicksPerBit / 2;
  localparam int TimerWidth  = $clog2(TicksPerBit);

  localparam logic [TimerWidth-1:0] BitEnd  = TimerWidth'(TicksPerBit - 1);
  localparam logic [TimerWidth-1:0] HalfEnd = TimerWidth'(HalfBit - 1);

  typedef enum logic [2:0] {
    sIdle,
    sStartBit,
    sDataBit,
    sStopBit,
    sBreak
  } state_t;

  state_t                state, stateNext;
  logic [TimerWidth-1:0] timer, timerNext;
  logic [2:0]            bitIndex, bitIndexNext;
  logic [7:0]            buffer, bufferNext;
  logic [7:0]            dataNext;
  logic                  receivedNext;
  logic                  frameErrorNext;
  logic                  sync1, rx;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      sync1 <= 1'b1;
      rx    <= 1'b1;
    end else begin
      sync1 <= iRXD;
      rx    <= sync1;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state           <= sIdle;
      timer           <= '0;
      bitIndex        <= '0;
      buffer          <= '0;
      rxBus.oData     <= '0;
      rxBus.oReceived <= 1'b0;
    end else begin
      state           <= stateNext;
      timer           <= timerNext;
      bitIndex        <= bitIndexNext;
      buffer          <= bufferNext;
      rxBus.oData     <= dataNext;
      rxBus.oReceived <= receivedNext;
    end
  end

`ifdef SERIAL_RECEIVER_FRAME_ERROR_EN
  always_ff @(posedge iClock) begin
    if (iReset) rxBus.oFrameError <= 1'b0;
    else        rxBus.oFrameError <= frameErrorNext;
  end
`endif

  assign rxBus.oBusy = (state != sIdle);

  always_comb begin
    stateNext      = state;
    timerNext      = timer + TimerWidth'(1);
    bitIndexNext   = bitIndex;
    bufferNext     = buffer;
    dataNext       = rxBus.oData;
    receivedNext   = 1'b0;
    frameErrorNext = 1'b0;
    unique case (state)
      sIdle: begin
        timerNext = '0;
        if (!rx) stateNext = sStartBit;
      end
      sStartBit: begin
        if (timer == HalfEnd) begin
          timerNext    = '0;
          bitIndexNext = '0;
          stateNext    = rx ? sIdle : sDataBit;
        end
      end
      sDataBit: begin
        if (timer == BitEnd) begin
          timerNext    = '0;
          bufferNext   = {rx, buffer[7:1]};
          bitIndexNext = bitIndex + 3'd1;
          if (bitIndex == 3'd7) stateNext = sStopBit;
        end
      end
      sStopBit: begin
        if (timer == BitEnd) begin
          timerNext = '0;
          if (rx) begin
            dataNext     = buffer;
            receivedNext = 1'b1;
            stateNext    = sIdle;
          end else begin
            bufferNext     = '0;
            frameErrorNext = 1'b1;
            stateNext      = sBreak;
          end
        end
      end
      sBreak: begin
        // A held-low line must not be mistaken for a fresh start bit.
        timerNext = '0;
        if (rx) stateNext = sIdle;
      end
      default: begin
        timerNext = '0;
        stateNext = sIdle;
      end
    endcase
  end

`ifndef SERIAL_RECEIVER_FRAME_ERROR_EN
  logic unusedFrameError;
  assign unusedFrameError = frameErrorNext;
`endif

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver at 16 MHz / 1 Mbaud (16 ticks per bit).
`timescale 1ns/1ps
module tb_serial_receiver;

  logic iClock;
  logic iReset;
  logic iRXD;

  serial_receiver_if rxBus ();

  serial_receiver #(
    .ClockFrequency(16000000),
    .BaudRate      (1000000)
  ) dut (
    .iClock(iClock),
    .iReset(iReset),
    .iRXD  (iRXD),
    .rxBus (rxBus)
  );

  initial begin
    iClock = 1'b0;
    forever #31.25 iClock = ~iClock;
  end

  int vectors     = 0;
  int miscompares = 0;
  int cycleCount  = 0;
  int strobeCount = 0;
  int frameErrors = 0;
  logic [7:0] expQ[$];
  int strobeCycles[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(posedge iClock) cycleCount++;

  // Monitor: every strobe must match the oldest expected byte.
  always @(negedge iClock) begin
    if (iReset === 1'b0 && rxBus.oReceived === 1'b1) begin
      strobeCount++;
      strobeCycles.push_back(cycleCount);
      if (expQ.size() == 0) begin
        check("unexpected strobe data", {24'd0, rxBus.oData}, 32'hDEAD);
      end else begin
        logic [7:0] e;
        e = expQ.pop_front();
        check("strobe data", {24'd0, rxBus.oData}, {24'd0, e});
      end
      check("busy low in strobe cycle", {31'd0, rxBus.oBusy}, 32'd0);
    end
`ifdef SERIAL_RECEIVER_FRAME_ERROR_EN
    if (iReset === 1'b0 && rxBus.oFrameError === 1'b1) frameErrors++;
`endif
  end

  task automatic waitClocks(input int n);
    repeat (n) @(negedge iClock);
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopBit);
    iRXD = 1'b0;
    waitClocks(16);
    for (int i = 0; i < 8; i++) begin
      iRXD = b[i];
      waitClocks(16);
    end
    iRXD = stopBit;
    waitClocks(16);
  endtask

  task automatic sendSkewed(input logic [7:0] b, input realtime bitTime);
    iRXD = 1'b0;
    #(bitTime);
    for (int i = 0; i < 8; i++) begin
      iRXD = b[i];
      #(bitTime);
    end
    iRXD = 1'b1;
    #(bitTime);
  endtask

  task automatic waitDrain(input string name, input int limit);
    for (int i = 0; i < limit && expQ.size() != 0; i++) @(negedge iClock);
    check({name, " drained"}, expQ.size(), 0);
    expQ.delete();
  endtask

  initial begin
    logic busySeen;
    int   strobesBefore;
    iReset = 1'b1;
    iRXD   = 1'b1;
    waitClocks(3);
    check("reset oData", {24'd0, rxBus.oData}, 32'h00);
    check("reset oReceived", {31'd0, rxBus.oReceived}, 32'd0);
    check("reset oBusy", {31'd0, rxBus.oBusy}, 32'd0);
    iReset = 1'b0;
    waitClocks(20);

    expQ.push_back(8'hA5);
    sendFrame(8'hA5, 1'b1);
    waitDrain("A5", 200);
    waitClocks(1);
    check("busy after A5", {31'd0, rxBus.oBusy}, 32'd0);
    waitClocks(20);

    expQ.push_back(8'h00);
    expQ.push_back(8'hFF);
    sendFrame(8'h00, 1'b1);
    sendFrame(8'hFF, 1'b1);
    waitDrain("back-to-back", 200);
    if (strobeCycles.size() >= 3)
      check("back-to-back spacing", strobeCycles[2] - strobeCycles[1], 160);
    else
      check("back-to-back strobe count", strobeCycles.size(), 3);
    waitClocks(20);

    strobesBefore = strobeCount;
    busySeen = 1'b0;
    iRXD = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge iClock);
      if (rxBus.oBusy) busySeen = 1'b1;
    end
    iRXD = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge iClock);
      if (rxBus.oBusy) busySeen = 1'b1;
    end
    check("glitch busy pulse", {31'd0, busySeen}, 32'd1);
    check("glitch busy returns low", {31'd0, rxBus.oBusy}, 32'd0);
    check("glitch no strobe", strobeCount - strobesBefore, 0);
    check("glitch oData held", {24'd0, rxBus.oData}, 32'hFF);

    strobesBefore = strobeCount;
    sendFrame(8'h55, 1'b0);
    waitClocks(40);
    check("break no strobe", strobeCount - strobesBefore, 0);
    check("break oData held", {24'd0, rxBus.oData}, 32'hFF);
    iRXD = 1'b1;
    waitClocks(32);
    expQ.push_back(8'h3C);
    sendFrame(8'h3C, 1'b1);
    waitDrain("3C after break", 200);
    waitClocks(20);

    iRXD = 1'b0;
    waitClocks(16);
    iRXD = 1'b1; waitClocks(16);
    iRXD = 1'b0; waitClocks(16);
    iRXD = 1'b0; waitClocks(16);
    iReset = 1'b1;
    iRXD   = 1'b1;
    waitClocks(1);
    iReset = 1'b0;
    check("midframe reset oData", {24'd0, rxBus.oData}, 32'h00);
    check("midframe reset oReceived", {31'd0, rxBus.oReceived}, 32'd0);
    check("midframe reset oBusy", {31'd0, rxBus.oBusy}, 32'd0);
`ifdef SERIAL_RECEIVER_FRAME_ERROR_EN
    check("midframe reset oFrameError", {31'd0, rxBus.oFrameError}, 32'd0);
`endif
    waitClocks(32);
    expQ.push_back(8'h81);
    sendFrame(8'h81, 1'b1);
    waitDrain("81 after reset", 200);
    waitClocks(20);

    expQ.push_back(8'h96);
    sendSkewed(8'h96, 961.538);
    waitDrain("96 fast", 200);
    waitClocks(20);
    expQ.push_back(8'h96);
    sendSkewed(8'h96, 1041.667);
    waitDrain("96 slow", 200);
    waitClocks(20);

    check("total strobes", strobeCount, 7);
`ifdef SERIAL_RECEIVER_FRAME_ERROR_EN
    check("frame error pulses", frameErrors, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
